// File: rtl/i2c_temp_target.sv
// I2C target exposing an ADT7420-style register map (temperature, config, device ID).
// Register updates land a few core cycles after synchronized SCL edges; no clock stretching, SCL is never driven.
module i2c_temp_target #(
    parameter logic [6:0] ADDR   = 7'h4B,
    parameter logic [7:0] DEV_ID = 8'hCB
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  config_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, scl_sync_d;
    logic [2:0]  sda_sync_q, sda_sync_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [15:0] snap_q, snap_d;
    logic        rw_q, rw_d;
    logic        first_q, first_d;
    logic        nack_q, nack_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;

    logic scl_now, scl_prev, sda_now, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] nxt_ptr, rd_byte;

    function automatic logic [7:0] rd_sel(input logic [7:0] p, input logic [15:0] s,
                                          input logic [7:0] c);
        case (p)
            8'h00:   rd_sel = s[15:8];
            8'h01:   rd_sel = s[7:0];
            8'h03:   rd_sel = c;
            8'h0B:   rd_sel = DEV_ID;
            default: rd_sel = 8'h00;
        endcase
    endfunction

    // [0],[1] are the synchronizer stages, [2] is the edge-detect history
    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_i};
        sda_sync_d = {sda_sync_q[1:0], sda_i};
    end

    assign scl_now   = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_now   = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        cfg_d     = cfg_q;
        snap_d    = snap_q;
        rw_d      = rw_q;
        first_d   = first_q;
        nack_d    = nack_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        nxt_ptr   = ptr_q + 8'd1;
        rd_byte   = 8'h00;

        case (state_q)
            S_IDLE: ;
            S_ADDR, S_WR_BYTE: begin
                if (scl_rise) begin
                    shreg_d   = {shreg_q[6:0], sda_now};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    if (state_q == S_WR_BYTE) begin
                        sda_oe_d = 1'b1;
                        state_d  = S_WR_ACK;
                    end else if (shreg_q[7:1] == ADDR) begin
                        rw_d     = shreg_q[0];
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = S_ADDR_ACK;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (scl_fall) begin
                    bit_cnt_d = 4'd0;
                    if (rw_q) begin
                        // First read byte comes straight from temp_in, matching the snapshot taken now
                        rd_byte  = rd_sel(ptr_q, temp_in, cfg_q);
                        snap_d   = temp_in;
                        shreg_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        state_d  = S_RD_BYTE;
                    end else begin
                        sda_oe_d = 1'b0;
                        first_d  = 1'b1;
                        state_d  = S_WR_BYTE;
                    end
                end
            end
            S_WR_ACK: begin
                if (scl_fall) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = S_WR_BYTE;
                    if (first_q) begin
                        ptr_d   = shreg_q;
                        first_d = 1'b0;
                    end else begin
                        if (ptr_q == 8'h03)
                            cfg_d = shreg_q;
                        ptr_d = nxt_ptr;
                    end
                end
            end
            S_RD_BYTE: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_RD_ACK;
                    end else begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        sda_oe_d = ~shreg_q[6];
                    end
                end
            end
            S_RD_ACK: begin
                if (scl_rise) begin
                    nack_d = sda_now;
                end else if (scl_fall) begin
                    if (nack_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_byte   = rd_sel(nxt_ptr, snap_q, cfg_q);
                        ptr_d     = nxt_ptr;
                        shreg_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 4'd0;
                        state_d   = S_RD_BYTE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop_det) begin
            state_d   = S_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 8'h00;
            ptr_q      <= 8'h00;
            cfg_q      <= 8'h00;
            snap_q     <= 16'h0000;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            nack_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            cfg_q      <= cfg_d;
            snap_q     <= snap_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            nack_q     <= nack_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign config_out = cfg_q;
    assign busy       = busy_q;

endmodule

// File: doc/i2c_temp_target.md
I2C_TEMP_TARGET -- requirements
Module: i2c_temp_target

Interface
REQ-001 Parameter ADDR, default 7'h4B, 7-bit I2C target address.
REQ-002 Parameter DEV_ID, default 8'hCB, value returned from register 0x0B.
REQ-003 clk_100MHz  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 scl_i  input  1  I2C SCL as seen on the bus; asynchronous.
REQ-006 sda_i  input  1  I2C SDA as seen on the bus; asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low, 0 = release; the top level ties SDA low when this is 1 and leaves it high-Z otherwise.
REQ-008 temp_in  input  16  temperature word {MSB, LSB}, ADT7420 13-bit format.
REQ-009 config_out  output  8  configuration register 0x03.
REQ-010 busy  output  1  high from an address match until STOP or repeated START.

Function
REQ-011 scl_i and sda_i SHALL pass through 2-flop synchronizers; edge and START/STOP detection use the synchronized values plus one history flop.
REQ-012 START is SDA falling while SCL high; STOP is SDA rising while SCL high; both detected in any state.
REQ-013 STOP SHALL force IDLE and release sda_oe on the next cycle.
REQ-014 START, including repeated START, SHALL force ADDR and clear the bit counter.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-016 Data bits SHALL be sampled on synchronized SCL rising edges, MSB first.
REQ-017 sda_oe SHALL change only on the cycle after a synchronized SCL falling edge.
REQ-018 ADDR: shift 8 bits; if bits[7:1]==ADDR, drive ACK (sda_oe=1) for the 9th clock and enter ADDR_ACK; on mismatch, return to IDLE with sda_oe=0 and wait for START.
REQ-019 R/W=0: after ADDR_ACK, enter WR_BYTE; the first byte loads the pointer, and each later byte writes the pointed register and then auto-increments the pointer; every byte is ACKed in WR_ACK.
REQ-020 Only register 0x03 is writable; writes to other addresses are ACKed and discarded.
REQ-021 R/W=1: at the ADDR_ACK falling edge, snapshot temp_in into a 16-bit holding register; all reads in that transaction use the snapshot.
REQ-022 RD_BYTE: shift out the pointed byte, driving sda_oe=~bit; 0x00=snapshot[15:8], 0x01=snapshot[7:0], 0x03=config, 0x0B=DEV_ID, any other address=8'h00.
REQ-023 RD_ACK: release SDA and sample the master's bit; ACK(0) increments the pointer and returns to RD_BYTE; NACK(1) goes to IDLE, which releases SDA until the next START.
REQ-024 The pointer is 8 bits, wraps 0xFF->0x00, and persists across transactions.
REQ-025 A STOP mid-byte SHALL abort the byte; a partial write byte is discarded and the pointer is unchanged.
REQ-026 No clock stretching; scl_i is never driven.

Reset
REQ-027 While reset_n=0: state=IDLE, sda_oe=0, busy=0, pointer=8'h00, config_out=8'h00, snapshot=16'h0000, synchronizers=1.
REQ-028 Reset assertion mid-transaction SHALL release SDA immediately, asynchronously.

Verification
REQ-029 Master write 0x96, 0x00, then repeated START and read 0x97 two bytes, with temp_in=16'h0C80 -> two ACKs, data 0x0C then 0x80, master NACK, sda_oe=0.
REQ-030 Address 0x90 (0x48 write) -> no ACK (sda_oe stays 0 for the 9th clock), busy stays 0.
REQ-031 Write pointer 0x03 with data 0xA0 -> config_out=0xA0 after the data ACK; read back gives 0xA0.
REQ-032 Pointer 0x0B read -> 0xCB; pointer 0xFF read with ACK -> 0x00 then pointer-0x00 byte (wrap).
REQ-033 temp_in changed during a read -> returned bytes equal the value at the snapshot point.
REQ-034 STOP after 4 bits of a write data byte -> config unchanged, state IDLE; reset_n pulsed mid-read -> sda_oe=0 within the same cycle.
